// File: rtl/fp_mul_writeback.sv
// FP multiplier result stage: buffers results in a small FIFO toward the FP register file, keeps sticky flags and a trap.
// Optional macro FP_NAN_CANONICAL_EN: stored NaNs are replaced by the canonical quiet NaN 32'h7FC00000.
//
// state   | meaning
// ST_RUN  | normal operation, new results accepted while the FIFO has room
// ST_TRAP | enabled exception fired; input stalled, FIFO keeps draining until flag_clear
module fp_mul_writeback #(
    parameter int DEPTH      = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_result,
    input  logic                  in_overflow,
    input  logic                  in_underflow,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [31:0]           wb_data,
    output logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [1:0]            enable_mask,
    input  logic                  flag_clear,
    output logic [1:0]            flags,
    output logic                  exception,
    output logic [1:0]            exception_cause
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           data_q [DEPTH];
    logic [REG_ADDR_W-1:0] dest_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [1:0]            flags_q, flags_d;
    logic [1:0]            cause_q, cause_d;

    logic                  accept, trap_hit, push, pop;
    logic [1:0]            op_flags;
    logic [31:0]           store_data;

`ifdef FP_NAN_CANONICAL_EN
    assign store_data = ((in_result[30:23] == 8'hFF) && (in_result[22:0] != 23'd0))
                        ? 32'h7FC0_0000 : in_result;
`else
    assign store_data = in_result;
`endif

    // Ready comes only from registered state so upstream never sees a combinational loop.
    assign in_ready        = (count_q < CNT_W'(DEPTH)) && (state_q == ST_RUN);
    assign wb_valid        = (count_q != '0);
    assign wb_data         = data_q[rd_ptr_q];
    assign wb_dest         = dest_q[rd_ptr_q];
    assign flags           = flags_q;
    assign exception       = (state_q == ST_TRAP);
    assign exception_cause = cause_q;

    always_comb begin
        op_flags = {in_overflow, in_underflow};
        accept   = in_valid && in_ready;
        trap_hit = |(op_flags & enable_mask);
        push     = accept && !trap_hit;
        pop      = wb_valid && wb_ready;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A same-cycle op's flags survive a clear.
        flags_d = (flag_clear ? 2'b00 : flags_q) | (accept ? op_flags : 2'b00);

        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_RUN: begin
                if (accept && trap_hit) begin
                    state_d = ST_TRAP;
                    cause_d = op_flags;
                end
            end
            ST_TRAP: begin
                if (flag_clear) begin
                    state_d = ST_RUN;
                    cause_d = 2'b00;
                end
            end
            default: begin
                state_d = ST_RUN;
                cause_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= 2'b00;
            cause_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            cause_q  <= cause_d;
        end
    end

    // Storage is reset so the head reads as zero while empty after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                dest_q[i] <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= store_data;
            dest_q[wr_ptr_q] <= in_dest;
        end
    end

endmodule

// File: doc/fp_mul_writeback.md
Name: fp_mul_writeback

Overview:
- Result stage directly downstream of the FP multiplier in the FPU datapath.
- Captures the multiplier's combinational result, overflow and underflow together with the destination FP register index. Buffers these in a small FIFO and drives the FP register-file write port through a valid/ready handshake.
- Keeps sticky exception flags and raises a trap when an enabled flag fires.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, >= 2.
- REG_ADDR_W, 5, width of the FP destination register index.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  multiplier result present this cycle.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  32  IEEE-754 single result from the multiplier.
- in_overflow  in  1  multiplier overflow.
- in_underflow  in  1  multiplier underflow.
- in_dest  in  REG_ADDR_W  destination FP register.
- wb_valid  out  1  write-back entry available.
- wb_ready  in  1  register file accepts the write.
- wb_data  out  32  value to write.
- wb_dest  out  REG_ADDR_W  register to write.
- enable_mask  in  2  trap enables: bit1 = overflow, bit0 = underflow.
- flag_clear  in  1  clears sticky flags and the trap.
- flags  out  2  sticky flags: bit1 = overflow, bit0 = underflow.
- exception  out  1  trap pending; level signal.
- exception_cause  out  2  flags of the operation that trapped.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - FIFO emptied; count = 0; state = RUN.
  - wb_valid = 0, wb_data = 0, wb_dest = 0.
  - flags = 0, exception = 0, exception_cause = 0.
  - in_ready = 1 after reset deasserts.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (count < DEPTH) && (state == RUN). It is derived from registered state only and never depends on in_valid or wb_ready.
- Trap condition on an accepted op: trap_hit = |({in_overflow, in_underflow} & enable_mask).
  - trap_hit = 0: entry {in_result, in_dest} pushed at the tail.
  - trap_hit = 1: entry not pushed (result dropped); state -> TRAP; exception = 1 from the next cycle; exception_cause = {in_overflow, in_underflow}.
- Sticky flags: flags |= {in_overflow, in_underflow} on every accepted op, trapped or not.
- State machine:
  - RUN: accepts input.
  - TRAP: in_ready = 0; FIFO keeps draining normally.
  - TRAP -> RUN on flag_clear. exception and exception_cause are cleared in the same edge.
- flag_clear:
  - Clears flags to 0 at the edge.
  - If an accepted op in the same cycle sets a flag, the new flag bits win: flags = new bits.
  - If that op also traps, the trap wins: state stays/enters TRAP.
- Output side:
  - wb_valid = (count != 0); wb_data/wb_dest = head entry. Both are stable while wb_valid && !wb_ready.
  - Pop when wb_valid && wb_ready; head pointer advances.
- Latency: one cycle from accept to wb_valid when the FIFO is empty. There is no combinational in->wb path.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Full (count == DEPTH): in_ready = 0, so there is no push; a pop in that cycle makes in_ready = 1 on the next cycle.
- Empty with wb_ready = 1: no pop, no underflow of count.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- in_valid while in_ready = 0: ignored. The upstream holds its operands; no data is lost inside this block.

Optional Feature:
- Macro: FP_NAN_CANONICAL_EN.
- Defined: any pushed in_result with bits[30:23] == 8'hFF and bits[22:0] != 0 is stored as 32'h7FC00000 (canonical quiet NaN, sign cleared). Infinities and numbers are unchanged.
- Undefined: in_result is stored bit-exact.

Test Plan:
- Reset, then push {32'h40400000, dest 3} with wb_ready = 1 -> next cycle wb_valid = 1, wb_data = 32'h40400000, wb_dest = 3; following cycle wb_valid = 0.
- wb_ready = 0, push 2 entries (DEPTH = 2) -> in_ready = 0 while full, and a third in_valid is ignored. wb_ready = 1 -> entries drain in order, one per cycle; in_ready = 1 after the first pop.
- enable_mask = 2'b00, push with in_overflow = 1 -> entry written; flags = 2'b10; exception = 0. flag_clear -> flags = 0.
- enable_mask = 2'b10, push {32'h7F800000, ovf = 1, dest 7} -> no write-back; exception = 1, exception_cause = 2'b10, in_ready = 0. flag_clear -> exception = 0, in_ready = 1.
- Assert reset asynchronously mid-drain with 2 entries queued -> wb_valid, flags and exception go to 0 immediately, without waiting for a clock edge.
- With FP_NAN_CANONICAL_EN defined, push 32'hFFC00001 -> wb_data = 32'h7FC00000. Without the macro -> wb_data = 32'hFFC00001.
